// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised multi-port register file with a per-register busy scoreboard
//   for pending writebacks. After reset a sequential walker zeroes x1..xN-1
//   one entry per cycle, so the array needs no parallel reset and can map to
//   RAM-style storage. x0 is hardwired to zero.
//
//   Optional build macro: REGFILE_BYPASS_EN
//     defined   : read ports forward same-cycle write data; a same-cycle
//                 writeback also counts as "not busy" for rd_busy and
//                 issue_ready
//     undefined : reads, rd_busy and issue_ready show pre-write state
//
// Ports
//   clock        core clock, all state on posedge
//   reset        synchronous active-high; restarts the clear walk
//   init_done    high once the clear walk has completed
//   rd_addr      packed read addresses, port i at [i*AW +: AW]
//   rd_data      packed combinational read data
//   rd_busy      scoreboard bit of each read address
//   wr_en        per write port enable
//   wr_addr      packed write addresses
//   wr_data      packed write data (higher port index wins on collision)
//   issue_valid  issue wants to reserve issue_addr
//   issue_addr   destination register being reserved
//   issue_ready  reservation is accepted when high together with issue_valid
//   busy_count   registered popcount of the busy vector
//   dbg_addr     debug read address
//   dbg_data     raw array value at dbg_addr (never forwarded)
//
// State | meaning
//   CLEAR | walker zeroing regs[ptr], ptr = 1..NUM_REGS-1; ports quiesced
//   RUN   | normal read / write / issue operation
module regfile_scoreboard #(
    parameter int XLEN        = 32,
    parameter int NUM_REGS    = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic                          init_done,
    input  logic [READ_PORTS*AW-1:0]      rd_addr,
    output logic [READ_PORTS*XLEN-1:0]    rd_data,
    output logic [READ_PORTS-1:0]         rd_busy,
    input  logic [WRITE_PORTS-1:0]        wr_en,
    input  logic [WRITE_PORTS*AW-1:0]     wr_addr,
    input  logic [WRITE_PORTS*XLEN-1:0]   wr_data,
    input  logic                          issue_valid,
    input  logic [AW-1:0]                 issue_addr,
    output logic                          issue_ready,
    output logic [AW:0]                   busy_count,
    input  logic [AW-1:0]                 dbg_addr,
    output logic [XLEN-1:0]               dbg_data
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [AW-1:0] LAST_REG = AW'(NUM_REGS - 1);

    state_t              state;
    logic [AW-1:0]       ptr;
    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] wr_hit;
    logic                issue_hit;

    function automatic logic [AW:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int j = 0; j < NUM_REGS; j++)
            c = c + {{AW{1'b0}}, v[j]};
        return c;
    endfunction

    // Registers targeted by any accepted write this cycle (x0 excluded).
    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < WRITE_PORTS; k++)
            if (init_done && wr_en[k] && wr_addr[k*AW +: AW] != '0)
                wr_hit[wr_addr[k*AW +: AW]] = 1'b1;
    end

    always_comb begin
        if (issue_addr == '0) begin
            issue_ready = init_done;
        end else begin
`ifdef REGFILE_BYPASS_EN
            issue_ready = init_done && (!busy[issue_addr] || wr_hit[issue_addr]);
`else
            issue_ready = init_done && !busy[issue_addr];
`endif
        end
    end

    assign issue_hit = issue_valid && issue_ready && (issue_addr != '0);

    // Writeback clears, issue sets; the set is applied last so it wins.
    always_comb begin
        busy_next = busy & ~wr_hit;
        if (issue_hit)
            busy_next[issue_addr] = 1'b1;
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            if (rd_addr[i*AW +: AW] != '0) begin
                rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
                rd_busy[i] = init_done && busy[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < WRITE_PORTS; k++)
                    if (init_done && wr_en[k] && wr_addr[k*AW +: AW] == rd_addr[i*AW +: AW])
                        rd_data[i*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
                if (wr_hit[rd_addr[i*AW +: AW]] &&
                    !(issue_hit && issue_addr == rd_addr[i*AW +: AW]))
                    rd_busy[i] = 1'b0;
`endif
            end
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= CLEAR;
            ptr        <= AW'(1);
            busy       <= '0;
            busy_count <= '0;
            init_done  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == LAST_REG) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    busy       <= busy_next;
                    busy_count <= popcount(busy_next);
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Storage has no reset branch; the walker zeroes it after every reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[ptr] <= '0;
            end else begin
                for (int k = 0; k < WRITE_PORTS; k++)
                    if (wr_en[k] && wr_addr[k*AW +: AW] != '0)
                        regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              init_done;
    logic [2*AW-1:0]   rd_addr = '0;
    logic [2*XLEN-1:0] rd_data;
    logic [1:0]        rd_busy;
    logic [1:0]        wr_en = '0;
    logic [2*AW-1:0]   wr_addr = '0;
    logic [2*XLEN-1:0] wr_data = '0;
    logic              issue_valid = 1'b0;
    logic [AW-1:0]     issue_addr = '0;
    logic              issue_ready;
    logic [AW:0]       busy_count;
    logic [AW-1:0]     dbg_addr = '0;
    logic [XLEN-1:0]   dbg_data;

    int tests = 0;
    int fails = 0;

    // Reference model: plain arrays updated once per clock edge.
    logic [XLEN-1:0] m_regs [NR];
    bit              m_busy [NR];
    int              m_left = 0;
    bit              m_run  = 1'b0;

    regfile_scoreboard dut (
        .clock(clock), .reset(reset), .init_done(init_done),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .busy_count(busy_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] wa(input int k);
        return wr_addr[k*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] wd(input int k);
        return wr_data[k*XLEN +: XLEN];
    endfunction

    function automatic bit write_hits(input logic [AW-1:0] a);
        for (int k = 0; k < 2; k++)
            if (wr_en[k] && wa(k) == a && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_ready(input logic [AW-1:0] a);
        if (!m_run) return 1'b0;
        if (a == 0 || !m_busy[a]) return 1'b1;
        return BYP && write_hits(a);
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        logic [XLEN-1:0] r;
        if (a == 0) return '0;
        r = m_regs[a];
        if (BYP && m_run)
            for (int k = 0; k < 2; k++)
                if (wr_en[k] && wa(k) == a) r = wd(k);
        return r;
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        if (!m_run || a == 0) return 1'b0;
        if (BYP && write_hits(a) && !(issue_valid && exp_ready(issue_addr) && issue_addr == a))
            return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic void mdl_edge();
        bit acc;
        if (reset) begin
            m_left = NR - 1;
            m_run  = 1'b0;
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end else if (!m_run) begin
            m_left--;
            if (m_left == 0) begin
                m_run = 1'b1;
                for (int i = 0; i < NR; i++) m_regs[i] = '0;
            end
        end else begin
            acc = issue_valid && exp_ready(issue_addr);
            for (int k = 0; k < 2; k++)
                if (wr_en[k] && wa(k) != 0) begin
                    m_regs[wa(k)] = wd(k);
                    m_busy[wa(k)] = 1'b0;
                end
            if (acc && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    endfunction

    task automatic tick();
        mdl_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en = '0;
        issue_valid = 1'b0;
    endtask

    task automatic do_reset_and_count(input string name);
        int n;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        issue_valid = 1'b1;
        issue_addr = 5'd5;
        rd_addr = {5'd5, 5'd5};
        n = 0;
        while (!init_done && n < 100) begin
            #1;
            tests++;
            if (issue_ready !== 1'b0 || rd_busy !== 2'b00) begin
                fails++;
                $display("FAIL %s_clear_quiet: got ready=%b busy=%b required 0/00", name, issue_ready, rd_busy);
            end
            tick();
            n++;
        end
        issue_valid = 1'b0;
        tests++;
        if (n !== 31) begin
            fails++;
            $display("FAIL %s_init_cycles: got %0d required 31", name, n);
        end
        tests++;
        if (busy_count !== 6'd0) begin
            fails++;
            $display("FAIL %s_busy_count: got %0d required 0", name, busy_count);
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if (init_done !== 1'b0 || busy_count !== 6'd0) begin
            fails++;
            $display("FAIL reset_state: got init=%b cnt=%0d required 0/0", init_done, busy_count);
        end
        do_reset_and_count("reset");
        for (int a = 0; a < NR; a++) begin
            rd_addr = {5'(a), 5'(a)};
            dbg_addr = 5'(a);
            #1;
            tests++;
            if (rd_data !== 64'd0 || dbg_data !== 32'd0) begin
                fails++;
                $display("FAIL reset_zero x%0d: got rd=%h dbg=%h required 0", a, rd_data, dbg_data);
            end
        end
    endtask

    task automatic test_write_read();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'd0, 32'hDEADBEEF};
        tick();
        idle();
        rd_addr = {5'd5, 5'd0};
        dbg_addr = 5'd5;
        #1;
        tests++;
        if (rd_data[63:32] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_read_port1: got %h required deadbeef", rd_data[63:32]);
        end
        tests++;
        if (dbg_data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_read_dbg: got %h required deadbeef", dbg_data);
        end
    endtask

    task automatic test_collision();
        wr_en = 2'b11;
        wr_addr = {5'd7, 5'd7};
        wr_data = {32'h22222222, 32'h11111111};
        tick();
        idle();
        rd_addr = {5'd0, 5'd7};
        #1;
        tests++;
        if (rd_data[31:0] !== 32'h22222222) begin
            fails++;
            $display("FAIL collision: got %h required 22222222", rd_data[31:0]);
        end
    endtask

    task automatic test_x0();
        wr_en = 2'b01;
        wr_addr = '0;
        wr_data = {32'd0, 32'hFFFFFFFF};
        issue_valid = 1'b1;
        issue_addr = 5'd0;
        #1;
        tests++;
        if (issue_ready !== 1'b1) begin
            fails++;
            $display("FAIL x0_issue_ready: got %b required 1", issue_ready);
        end
        tick();
        idle();
        rd_addr = '0;
        dbg_addr = '0;
        #1;
        tests++;
        if (rd_data !== 64'd0 || dbg_data !== 32'd0 || busy_count !== 6'd0) begin
            fails++;
            $display("FAIL x0_hardwired: got rd=%h dbg=%h cnt=%0d required 0/0/0", rd_data, dbg_data, busy_count);
        end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1;
        issue_addr = 5'd9;
        #1;
        tests++;
        if (issue_ready !== 1'b1) begin
            fails++;
            $display("FAIL sb_first_issue: got %b required 1", issue_ready);
        end
        tick();
        rd_addr = {5'd0, 5'd9};
        #1;
        tests++;
        if (busy_count !== 6'd1 || rd_busy[0] !== 1'b1 || issue_ready !== 1'b0) begin
            fails++;
            $display("FAIL sb_busy: got cnt=%0d rdb=%b rdy=%b required 1/1/0", busy_count, rd_busy[0], issue_ready);
        end
        tick();
        issue_valid = 1'b0;
        wr_en = 2'b10;
        wr_addr = {5'd9, 5'd0};
        wr_data = {32'h42, 32'h0};
        tick();
        idle();
        #1;
        tests++;
        if (busy_count !== 6'd0 || rd_busy[0] !== 1'b0 || issue_ready !== 1'b1 || rd_data[31:0] !== 32'h42) begin
            fails++;
            $display("FAIL sb_writeback: got cnt=%0d rdb=%b rdy=%b d=%h required 0/0/1/42",
                     busy_count, rd_busy[0], issue_ready, rd_data[31:0]);
        end
        issue_valid = 1'b1;
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd9};
        wr_data = {32'h0, 32'h43};
        tick();
        idle();
        #1;
        tests++;
        if (busy_count !== 6'd1 || rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h43) begin
            fails++;
            $display("FAIL sb_set_wins: got cnt=%0d rdb=%b d=%h required 1/1/43", busy_count, rd_busy[0], rd_data[31:0]);
        end
        wr_en = 2'b01;
        tick();
        idle();
        tests++;
        if (busy_count !== 6'd0) begin
            fails++;
            $display("FAIL sb_release: got %0d required 0", busy_count);
        end
    endtask

    task automatic test_bypass();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd4};
        wr_data = {32'h0, 32'h1};
        tick();
        wr_en = 2'b00;
        issue_valid = 1'b1;
        issue_addr = 5'd4;
        tick();
        idle();
        tests++;
        if (busy_count !== 6'd1) begin
            fails++;
            $display("FAIL bypass_setup: got cnt=%0d required 1", busy_count);
        end
        wr_en = 2'b01;
        wr_data = {32'h0, 32'h5};
        rd_addr = {5'd0, 5'd4};
        issue_addr = 5'd4;
        #1;
        tests++;
        if (rd_data[31:0] !== (BYP ? 32'h5 : 32'h1)) begin
            fails++;
            $display("FAIL bypass_data: got %h required %h", rd_data[31:0], BYP ? 32'h5 : 32'h1);
        end
        tests++;
        if (rd_busy[0] !== !BYP || issue_ready !== BYP) begin
            fails++;
            $display("FAIL bypass_busy: got rdb=%b rdy=%b required %b/%b", rd_busy[0], issue_ready, !BYP, BYP);
        end
        tick();
        idle();
        #1;
        tests++;
        if (rd_data[31:0] !== 32'h5 || busy_count !== 6'd0) begin
            fails++;
            $display("FAIL bypass_after: got d=%h cnt=%0d required 5/0", rd_data[31:0], busy_count);
        end
    endtask

    task automatic test_reset_restart();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        do_reset_and_count("midclear");
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd3};
        wr_data = {32'h0, 32'h77};
        issue_valid = 1'b1;
        issue_addr = 5'd3;
        tick();
        idle();
        tests++;
        if (busy_count !== 6'd1) begin
            fails++;
            $display("FAIL midrun_setup: got cnt=%0d required 1", busy_count);
        end
        do_reset_and_count("midrun");
        rd_addr = {5'd3, 5'd3};
        #1;
        tests++;
        if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL midrun_x3: got d=%h b=%b required 0/00", rd_data, rd_busy);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a0, a1;
        for (int c = 0; c < 400; c++) begin
            wr_en = 2'($urandom_range(0, 3));
            wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_data = {$urandom(), $urandom()};
            issue_valid = 1'($urandom_range(0, 1));
            issue_addr = 5'($urandom_range(0, 7));
            a0 = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            rd_addr = {a1, a0};
            dbg_addr = 5'($urandom_range(0, 7));
            #1;
            tests++;
            if (rd_data[31:0] !== exp_rd(a0) || rd_data[63:32] !== exp_rd(a1)) begin
                fails++;
                $display("FAIL rand_rd c%0d: got %h required %h_%h", c, rd_data, exp_rd(a1), exp_rd(a0));
            end
            tests++;
            if (rd_busy !== {exp_busy(a1), exp_busy(a0)}) begin
                fails++;
                $display("FAIL rand_busy c%0d: got %b required %b%b", c, rd_busy, exp_busy(a1), exp_busy(a0));
            end
            tests++;
            if (issue_ready !== exp_ready(issue_addr)) begin
                fails++;
                $display("FAIL rand_ready c%0d: got %b required %b", c, issue_ready, exp_ready(issue_addr));
            end
            tests++;
            if (dbg_data !== ((dbg_addr == 0) ? 32'd0 : m_regs[dbg_addr])) begin
                fails++;
                $display("FAIL rand_dbg c%0d: got %h required %h", c, dbg_data, m_regs[dbg_addr]);
            end
            tick();
            tests++;
            if (int'(busy_count) !== exp_count() || init_done !== 1'b1) begin
                fails++;
                $display("FAIL rand_count c%0d: got %0d/%b required %0d/1", c, busy_count, init_done, exp_count());
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_x0();
        test_scoreboard();
        test_bypass();
        test_reset_restart();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's single-write register file.
- Adds configurable width and depth, N read ports, M write ports, and a per-register busy scoreboard for pending writebacks.
- Adds a sequential post-reset clear walker, so the array maps to RAM-style storage without a parallel reset.
- Sits between decode/issue (read and issue ports) and writeback (write ports); the debug read port generalises the fixed x31 tap.

Parameters:
XLEN, 32, register width in bits
NUM_REGS, 32, register count (power of 2, >=2); AW = $clog2(NUM_REGS)
READ_PORTS, 2, number of combinational read ports (1..4)
WRITE_PORTS, 2, number of write ports (1..4); higher index has priority

Ports:
clock  in  1  core clock, all state on posedge
reset  in  1  synchronous, active-high; restarts clear sequence
init_done  out  1  high once the clear walk completes
rd_addr  in  READ_PORTS*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  out  READ_PORTS*XLEN  packed read data
rd_busy  out  READ_PORTS  scoreboard bit of each read address
wr_en  in  WRITE_PORTS  per-port write enable
wr_addr  in  WRITE_PORTS*AW  write addresses
wr_data  in  WRITE_PORTS*XLEN  write data
issue_valid  in  1  issue wants to reserve destination issue_addr
issue_addr  in  AW  destination register being reserved
issue_ready  out  1  reservation accepted this cycle when high with issue_valid
busy_count  out  AW+1  registered count of set busy bits
dbg_addr  in  AW  debug read address
dbg_data  out  XLEN  debug read data (no forwarding)

Behaviour:
- Reset is synchronous and active-high; the clock is named clock and the reset is named reset.
- FSM states: CLEAR, RUN. Reset in any state forces CLEAR with walk pointer = 1, all busy bits = 0, busy_count = 0, init_done = 0.
- CLEAR: each cycle writes 0 to regs[ptr] and increments ptr.
  - After writing NUM_REGS-1, moves to RUN next cycle; init_done goes high the cycle after the last clear write.
  - Clear takes NUM_REGS-1 cycles (31 at default).
  - While in CLEAR: wr_en is ignored, issue_ready = 0, rd_busy = 0.
  - Reset asserted mid-clear restarts the walk at 1.
- x0 is hardwired:
  - reads return 0 on every port, including dbg;
  - writes to x0 are dropped;
  - issue to x0 never sets busy;
  - issue_ready for x0 = init_done.
- Reads:
  - combinational, zero latency;
  - rd_data[i] = regs[rd_addr[i]];
  - rd_busy[i] = busy[rd_addr[i]], with bit 0 forced to 0.
- Writes (RUN only): at posedge, for every port with wr_en[k] and wr_addr[k] != 0, regs[wr_addr[k]] <= wr_data[k].
  - On an address collision, the highest k wins.
  - A write clears busy[wr_addr[k]].
- Issue:
  - issue_ready = init_done && (issue_addr == 0 || !busy[issue_addr]); this is combinational and ignores same-cycle writes.
  - On accept with issue_addr != 0, busy[issue_addr] is set at posedge.
  - Same-cycle accept and writeback to the same address: set wins, so busy stays 1 and data is updated.
- busy_count: registered popcount of the next busy vector, valid the cycle after each change; maximum NUM_REGS-1.
- dbg_data = regs[dbg_addr], raw array value; never forwarded.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - rd_data[i] returns the same-cycle winning wr_data for a matching wr_addr != 0 (RUN only).
  - rd_busy[i] reads 0 when a same-cycle write targets that address, unless a same-cycle issue accept also targets it.
  - issue_ready also treats a same-cycle write to issue_addr as not busy.
- Undefined: reads and rd_busy show pre-write state; issue_ready uses the registered busy bit only.

Test Plan:
- Reset 1 cycle, then idle -> init_done low for exactly 31 cycles then high; all rd_data = 0; busy_count = 0.
- After init, write x5 = 0xDEADBEEF via port 0; next cycle read x5 on port 1 -> 0xDEADBEEF; dbg_addr = 5 -> 0xDEADBEEF.
- Same cycle, port 0 writes x7 = 0x11111111 and port 1 writes x7 = 0x22222222 -> x7 reads 0x22222222.
- Write x0 = 0xFFFFFFFF; issue x0 -> x0 reads 0; busy_count stays 0; issue_ready = 1.
- Issue x9 -> busy_count = 1, rd_busy for x9 = 1, second issue x9 gets issue_ready = 0; writeback x9 = 0x42 -> busy cleared, issue_ready = 1. Same-cycle issue x9 and write x9 -> busy stays 1.
- Assert reset 10 cycles into the clear walk and at mid-RUN with x3 busy -> walk restarts (31 more cycles), busy_count = 0, x3 = 0 after init. With REGFILE_BYPASS_EN, a same-cycle write of x4 = 0x5 reads 0x5; without it, the old value is returned.
